// File: rtl/mixer_iq_pipe_if.sv
// Sample/LO input bundle and baseband result bundle for mixer_iq_pipe.
// The master drives samples and LO words, and the slave returns the mixed products.
interface mixer_iq_pipe_if #(
    parameter int DATA_W = 16,
    parameter int LO_W   = 16,
    parameter int OUT_W  = 16
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] signal;
    logic signed [LO_W-1:0]   cosine;
    logic signed [LO_W-1:0]   sine;
    logic                     conj;
    logic                     out_valid;
    logic signed [OUT_W-1:0]  signal_real;
    logic signed [OUT_W-1:0]  signal_img;
    logic                     sat_flag;

    modport master (
        output in_valid, signal, cosine, sine, conj,
        input  out_valid, signal_real, signal_img, sat_flag
    );

    modport slave (
        input  in_valid, signal, cosine, sine, conj,
        output out_valid, signal_real, signal_img, sat_flag
    );
endinterface

// File: rtl/mixer_iq_pipe.sv
// Three-stage I/Q downconversion mixer: register, multiply, round/saturate.
// Optional MIXER_SAT_COUNT_EN adds a saturating 16-bit clamp-event counter port.
module mixer_iq_pipe #(
    parameter int DATA_W = 16,
    parameter int LO_W   = 16,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    mixer_iq_pipe_if.slave    bus
`ifdef MIXER_SAT_COUNT_EN
    ,
    output logic [15:0]       sat_count
`endif
);
    localparam int SHIFT = DATA_W + LO_W - 1 - OUT_W;
    // One extra bit so that negating min*min cannot overflow.
    localparam int PW    = DATA_W + LO_W + 1;

    localparam logic signed [PW:0] RND  = (PW+1)'(1) << (SHIFT - 1);
    localparam logic signed [PW:0] MAXV = {{(PW-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW:0] MINV = {{(PW-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    generate
        if (SHIFT < 1) begin : g_bad_shift
            $error("mixer_iq_pipe: DATA_W+LO_W-1-OUT_W must be >= 1");
        end
    endgenerate

    // Stage 1: input capture
    logic                     v1_reg;
    logic signed [DATA_W-1:0] sig_reg;
    logic signed [LO_W-1:0]   cos_reg;
    logic signed [LO_W-1:0]   sin_reg;
    logic                     conj_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_reg   <= 1'b0;
            sig_reg  <= '0;
            cos_reg  <= '0;
            sin_reg  <= '0;
            conj_reg <= 1'b0;
        end else begin
            v1_reg <= bus.in_valid & ~clr;
            if (bus.in_valid && !clr) begin
                sig_reg  <= bus.signal;
                cos_reg  <= bus.cosine;
                sin_reg  <= bus.sine;
                conj_reg <= bus.conj;
            end
        end
    end

    // Stage 2: full-precision products, conjugate applied to the imaginary arm
    logic                 v2_reg;
    logic signed [PW-1:0] prod_reg [2];
    logic signed [PW-1:0] prod_r_next;
    logic signed [PW-1:0] prod_i_raw;

    assign prod_r_next = PW'(sig_reg) * PW'(cos_reg);
    assign prod_i_raw  = PW'(sig_reg) * PW'(sin_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_reg      <= 1'b0;
            prod_reg[0] <= '0;
            prod_reg[1] <= '0;
        end else begin
            v2_reg <= v1_reg & ~clr;
            if (v1_reg && !clr) begin
                prod_reg[0] <= prod_r_next;
                prod_reg[1] <= conj_reg ? -prod_i_raw : prod_i_raw;
            end
        end
    end

    // Stage 3: round half up, arithmetic shift, clamp (index 0 = real, 1 = imag)
    logic signed [OUT_W-1:0] res_next [2];
    logic                    sat_next [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [PW:0] sum_next;
            logic signed [PW:0] shr_next;
            logic               hi_next;
            logic               lo_next;

            assign sum_next = {prod_reg[gi][PW-1], prod_reg[gi]} + RND;
            assign shr_next = sum_next >>> SHIFT;
            assign hi_next  = shr_next > MAXV;
            assign lo_next  = shr_next < MINV;
            assign sat_next[gi] = hi_next | lo_next;
            assign res_next[gi] = hi_next ? MAXV[OUT_W-1:0] :
                                  lo_next ? MINV[OUT_W-1:0] : shr_next[OUT_W-1:0];
        end
    endgenerate

    logic any_sat;
    assign any_sat = v2_reg & (sat_next[0] | sat_next[1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid   <= 1'b0;
            bus.signal_real <= '0;
            bus.signal_img  <= '0;
            bus.sat_flag    <= 1'b0;
        end else begin
            bus.out_valid <= v2_reg & ~clr;
            // clr keeps the last results on the bus rather than zeroing them
            if (v2_reg && !clr) begin
                bus.signal_real <= res_next[0];
                bus.signal_img  <= res_next[1];
            end
            if (clr)
                bus.sat_flag <= 1'b0;
            else if (any_sat)
                bus.sat_flag <= 1'b1;
        end
    end

`ifdef MIXER_SAT_COUNT_EN
    logic [15:0] sat_count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_count_reg <= '0;
        else if (clr)
            sat_count_reg <= '0;
        else if (any_sat && sat_count_reg != 16'hFFFF)
            sat_count_reg <= sat_count_reg + 16'd1;
    end

    assign sat_count = sat_count_reg;
`endif

endmodule
